// File: rtl/rs232_tx_arbiter_if.sv
// rtl/rs232_tx_arbiter_if.sv - requester/transmitter signal bundle for rs232_tx_arbiter
// Ports (slave = arbiter side):
//   req_valid/req_last/req_data/req_ready : per-requester byte handshake
//   abort, tx_abort                        : global abort in, transmitter clear out
//   tx_datain, tx_datain_ready, tx_busy    : transmitter byte, start pulse, busy flag
//   grant, locked, gap_timeout             : arbitration status
interface rs232_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 abort;
    logic [7:0]           tx_datain;
    logic                 tx_datain_ready;
    logic                 tx_abort;
    logic                 tx_busy;
    logic [NUM_REQ-1:0]   grant;
    logic                 locked;
    logic                 gap_timeout;

    modport slave (
        input  req_valid, req_last, req_data, abort, tx_busy,
        output req_ready, tx_datain, tx_datain_ready, tx_abort, grant, locked, gap_timeout
    );

    modport master (
        output req_valid, req_last, req_data, abort, tx_busy,
        input  req_ready, tx_datain, tx_datain_ready, tx_abort, grant, locked, gap_timeout
    );
endinterface

// File: rtl/rs232_tx_arbiter.sv
// rtl/rs232_tx_arbiter.sv - round-robin arbiter sharing one RS-232 byte transmitter
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : rs232_tx_arbiter_if.slave (requester handshakes, transmitter, status)
module rs232_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int GAP_TIMEOUT   = 1024,
    parameter int GAP_CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    rs232_tx_arbiter_if.slave    bus
);
    localparam int IDX_W = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ);
    localparam logic [GAP_CNT_WIDTH-1:0] GAP_LAST =
        GAP_CNT_WIDTH'((GAP_TIMEOUT == 0) ? 0 : GAP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_ptr;
    logic [7:0]             r_tx_datain;
    logic                   r_tx_start;
    logic [NUM_REQ-1:0]     r_grant;
    logic                   r_locked;
    logic                   r_gap_to;
    logic [GAP_CNT_WIDTH-1:0] r_gap_cnt;

    logic                   w_found;
    logic [IDX_W-1:0]       w_win;
    logic [NUM_REQ-1:0]     w_win_onehot;
    logic [7:0]             w_win_data;
    logic                   w_win_last;
    logic                   w_accept;
    logic                   w_owner_valid;

    // Round-robin search starting just after the last winner. While locked,
    // only the grant owner may win so a packet is never interleaved.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && bus.req_valid[idx] && (!r_locked || r_grant[idx])) begin
                w_found = 1'b1;
                w_win   = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        w_win_onehot = '0;
        w_win_data   = 8'h00;
        w_win_last   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_win_onehot[i] = 1'b1;
                w_win_data      = bus.req_data[i*8 +: 8];
                w_win_last      = bus.req_last[i];
            end
        end
    end

    // Abort suppresses acceptance in the same cycle.
    assign w_accept      = (r_state == IDLE) && w_found && !bus.abort;
    // The pointer always holds the last winner, which is the lock owner.
    assign w_owner_valid = bus.req_valid[r_ptr];

    assign bus.req_ready       = w_accept ? w_win_onehot : '0;
    assign bus.tx_abort        = bus.abort;
    assign bus.tx_datain       = r_tx_datain;
    assign bus.tx_datain_ready = r_tx_start;
    assign bus.grant           = r_grant;
    assign bus.locked          = r_locked;
    assign bus.gap_timeout     = r_gap_to;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_tx_datain <= 8'hFF;
            r_tx_start  <= 1'b0;
            r_grant     <= '0;
            r_locked    <= 1'b0;
            r_gap_to    <= 1'b0;
            r_gap_cnt   <= '0;
        end else begin
            r_tx_start <= 1'b0;
            r_gap_to   <= 1'b0;
            if (bus.abort) begin
                // Pointer is left alone; an accepted-but-unsent byte is dropped.
                r_state     <= IDLE;
                r_locked    <= 1'b0;
                r_gap_cnt   <= '0;
                r_tx_datain <= 8'hFF;
                r_grant     <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_tx_datain <= w_win_data;
                            r_grant     <= w_win_onehot;
                            r_ptr       <= w_win;
                            r_locked    <= ~w_win_last;
                            r_gap_cnt   <= '0;
                            r_tx_start  <= 1'b1;
                            r_state     <= START;
                        end else if (r_locked && !w_owner_valid) begin
                            if ((GAP_TIMEOUT != 0) && (r_gap_cnt == GAP_LAST)) begin
                                r_locked  <= 1'b0;
                                r_gap_to  <= 1'b1;
                                r_gap_cnt <= '0;
                            end else begin
                                r_gap_cnt <= r_gap_cnt + 1'b1;
                            end
                        end else if (!r_locked) begin
                            r_gap_cnt <= '0;
                        end
                    end
                    START: begin
                        r_state <= WAIT_BUSY;
                    end
                    WAIT_BUSY: begin
                        if (bus.tx_busy) begin
                            r_state <= WAIT_DONE;
                        end
                    end
                    WAIT_DONE: begin
                        if (!bus.tx_busy) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule
